// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM states, key bit positions
// as seen by the password-lock encoder, and a small popcount helper.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } key_state_t;

  // Bit index = row*4 + col, matching the lock's decoder.
  localparam int KEY_ENTER = 0;
  localparam int KEY_0     = 3;
  localparam int KEY_3     = 5;
  localparam int KEY_2     = 6;
  localparam int KEY_1     = 7;
  localparam int KEY_CLEAR = 8;
  localparam int KEY_6     = 9;
  localparam int KEY_5     = 10;
  localparam int KEY_4     = 11;
  localparam int KEY_RESET = 12;
  localparam int KEY_9     = 13;
  localparam int KEY_8     = 14;
  localparam int KEY_7     = 15;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'b0000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous inputs,
// with a configurable synchronous reset value.
module keypad_sync #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan_onehot.sv
// 4x4 keypad scanner: rotates an active-low column drive, builds a key map
// per scan frame, debounces a single key over whole frames, and presents it onehot.
module keypad_scan_onehot
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 5,
  parameter int HOLD_LAST       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [15:0] onehot,
  output logic        key_down,
  output logic        key_pulse,
  output logic        multi_key,
  output logic [1:0]  dbg_state
);

  localparam int                 DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int                 CNT_W    = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_DONE = CNT_W'(DEBOUNCE_FRAMES);

  logic [3:0]       w_row_s;
  logic             w_sample;
  logic             w_frame_end;
  logic [15:0]      w_map;
  logic [4:0]       w_pop;
  logic             w_single;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_inc;

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col;
  logic [3:0]       r_col_n;
  logic [15:0]      r_raw;

  key_state_t       r_state;
  logic [15:0]      r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_onehot;
  logic             r_key_down;
  logic             r_key_pulse;
  logic             r_multi_key;

  keypad_sync #(
    .W       (4),
    .RST_VAL (4'b1111)
  ) u_row_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (row_n),
    .o_q   (w_row_s)
  );

  assign w_sample    = (r_div == DIV_LAST);
  assign w_frame_end = w_sample && (r_col == 2'd3);

  // Raw map with the active column's samples merged in; on the last slot
  // this is the complete frame map that the debouncer evaluates.
  always_comb begin
    w_map = r_raw;
    for (int r = 0; r < NUM_ROWS; r++) begin
      w_map[{2'(r), r_col}] = ~w_row_s[2'(r)];
    end
  end

  assign w_pop     = popcount16(w_map);
  assign w_single  = (w_pop == 5'd1);
  assign w_match   = (w_map == r_cand);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_col   <= 2'd0;
      r_col_n <= 4'b1110;
      r_raw   <= '0;
    end else if (w_sample) begin
      r_div   <= '0;
      r_col   <= r_col + 2'd1;
      r_col_n <= {r_col_n[2:0], r_col_n[3]};
      r_raw   <= (r_col == 2'd3) ? 16'h0000 : w_map;
    end else begin
      r_div   <= r_div + DIV_W'(1);
    end
  end

  // Debounce FSM; every decision is taken only on the frame-end cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_onehot    <= '0;
      r_key_down  <= 1'b0;
      r_key_pulse <= 1'b0;
      r_multi_key <= 1'b0;
    end else begin
      r_key_pulse <= 1'b0;
      if (w_frame_end) begin
        r_multi_key <= (w_pop > 5'd1);
        case (r_state)
          ST_IDLE: begin
            if (w_single) begin
              r_cand <= w_map;
              if (DEBOUNCE_FRAMES == 1) begin
                r_state     <= ST_HELD;
                r_cnt       <= '0;
                r_onehot    <= w_map;
                r_key_down  <= 1'b1;
                r_key_pulse <= 1'b1;
              end else begin
                r_state <= ST_PRESS;
                r_cnt   <= CNT_W'(1);
              end
            end
          end
          ST_PRESS: begin
            if (!w_match) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else if (w_cnt_inc == CNT_DONE) begin
              r_state     <= ST_HELD;
              r_cnt       <= '0;
              r_onehot    <= r_cand;
              r_key_down  <= 1'b1;
              r_key_pulse <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          ST_HELD: begin
            if (!w_match) begin
              if (DEBOUNCE_FRAMES == 1) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                r_key_down <= 1'b0;
                if (HOLD_LAST == 0) r_onehot <= '0;
              end else begin
                r_state <= ST_RELEASE;
                r_cnt   <= CNT_W'(1);
              end
            end
          end
          ST_RELEASE: begin
            if (w_match) begin
              r_state <= ST_HELD;
              r_cnt   <= '0;
            end else if (w_cnt_inc == CNT_DONE) begin
              r_state    <= ST_IDLE;
              r_cnt      <= '0;
              r_key_down <= 1'b0;
              if (HOLD_LAST == 0) r_onehot <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign col_n     = r_col_n;
  assign onehot    = r_onehot;
  assign key_down  = r_key_down;
  assign key_pulse = r_key_pulse;
  assign multi_key = r_multi_key;
  assign dbg_state = r_state;

endmodule
